// File: rtl/eeprom_write_sequencer.sv
// ---------------------------------------------------------------------------
// eeprom_write_sequencer
//
// Feeds single-byte write requests to the I2C EEPROM byte-write engine.
// Requests (16-bit address + 8-bit data) are buffered in a small FIFO and
// launched one at a time. After the engine reports the transfer finished,
// the sequencer waits out the EEPROM internal write-cycle time (tWR) before
// the next launch.
//
// Ports:
//   clk_50M        in   system clock
//   reset          in   synchronous, active-high reset
//   req_valid      in   request present
//   req_ready      out  FIFO can accept (not full)
//   req_address    in   EEPROM byte address of the request
//   req_data       in   byte to write
//   write          out  launch level to the I2C writer
//   write_control  out  constant control byte {4'b1010, DEV_SEL, 1'b0}
//   write_address  out  address of the in-flight request (held)
//   write_data     out  data of the in-flight request (held)
//   write_complete in   writer status: 1 = idle, 0 = transfer running
//   busy           out  sequencer is not idle
//   done_pulse     out  one-cycle pulse at the end of tWR for each request
//   pending        out  FIFO occupancy, 0..DEPTH
//   error          out  sticky watchdog flag
//
// Optional feature macro: EEPROM_SEQ_WATCHDOG_EN
//   When defined, a watchdog aborts a request that stays in LAUNCH/XFER for
//   TIMEOUT_CYCLES clocks, sets the sticky error flag and still observes tWR.
//   When undefined, error is tied low and LAUNCH/XFER wait indefinitely.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module eeprom_write_sequencer #(
    parameter int         DEPTH          = 4,
    parameter int         TWR_CYCLES     = 250000,
    parameter logic [2:0] DEV_SEL        = 3'b000,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk_50M,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [15:0]            req_address,
    input  logic [7:0]             req_data,
    output logic                   write,
    output logic [7:0]             write_control,
    output logic [15:0]            write_address,
    output logic [7:0]             write_data,
    input  logic                   write_complete,
    output logic                   busy,
    output logic                   done_pulse,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   error
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    // One shared counter serves both the tWR wait and the watchdog, so it is
    // sized for the larger of the two limits.
    localparam int CMAX = (TWR_CYCLES > TIMEOUT_CYCLES) ? TWR_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] TWR_LAST   = CW'(TWR_CYCLES - 1);
    localparam logic [PW-1:0] FULL_COUNT = PW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_XFER,
        S_TWR
    } state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [15:0]     r_fifoAddr [DEPTH];
    logic [7:0]      r_fifoData [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [PW-1:0]   r_count;

    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_writeAddress;
    logic [7:0]      r_writeData;

    logic            w_push;
    logic            w_pop;
    logic            w_timeout;
    logic            w_suppressDone;

    assign req_ready     = (r_count != FULL_COUNT);
    assign w_push        = req_valid & req_ready;
    assign pending       = r_count;
    assign busy          = (r_state != S_IDLE);
    assign write_control = {4'b1010, DEV_SEL, 1'b0};
    assign write_address = r_writeAddress;
    assign write_data    = r_writeData;

`ifdef EEPROM_SEQ_WATCHDOG_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic r_error;
    logic r_aborted;

    assign w_timeout      = ((r_state == S_LAUNCH) || (r_state == S_XFER)) && (r_cnt == TIMEOUT_LAST);
    assign w_suppressDone = r_aborted;
    assign error          = r_error;

    // Watchdog bookkeeping: error is sticky until reset; r_aborted remembers
    // that the current tWR wait follows a timeout so it ends without a
    // done_pulse, and is cleared once the sequencer is back in IDLE.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_error   <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_error   <= 1'b1;
                r_aborted <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_aborted <= 1'b0;
            end
        end
    end
`else
    assign w_timeout      = 1'b0;
    assign w_suppressDone = 1'b0;
    assign error          = 1'b0;
`endif

    // FIFO storage. Entries need no reset because occupancy is tracked
    // separately and a reset empties the queue logically.
    always_ff @(posedge clk_50M) begin
        if (w_push) begin
            r_fifoAddr[r_wrPtr] <= req_address;
            r_fifoData[r_wrPtr] <= req_data;
        end
    end

    // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers
    // wrap naturally. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The in-flight request is captured on the pop and held until the next
    // pop, because the writer samples address and data live during the
    // transfer.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_writeAddress <= '0;
            r_writeData    <= '0;
        end else if (w_pop) begin
            r_writeAddress <= r_fifoAddr[r_rdPtr];
            r_writeData    <= r_fifoData[r_rdPtr];
        end
    end

    // Per-state cycle counter: cleared on every state entry, saturating so a
    // long wait in LAUNCH never wraps back to zero.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_nextState != r_state) begin
            r_cnt <= '0;
        end else if (r_cnt != {CW{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and output decode. In LAUNCH the counter must be non-zero
    // before leaving, which keeps write high for at least two clocks even if
    // write_complete were already low.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        write       = 1'b0;
        done_pulse  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && write_complete) begin
                    w_pop       = 1'b1;
                    w_nextState = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                write = 1'b1;
                if (w_timeout) begin
                    w_nextState = S_TWR;
                end else if (!write_complete && (r_cnt != '0)) begin
                    w_nextState = S_XFER;
                end
            end
            S_XFER: begin
                if (w_timeout || write_complete) begin
                    w_nextState = S_TWR;
                end
            end
            S_TWR: begin
                if (r_cnt == TWR_LAST) begin
                    done_pulse  = !w_suppressDone;
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_eeprom_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_eeprom_write_sequencer
//
// Directed plus randomized bench for eeprom_write_sequencer. A queue-based
// reference model tracks accepted requests and predicts launch order,
// occupancy, done_pulse timing and held address/data. A behavioural writer
// drops write_complete 2 clocks after write rises and raises it 50 clocks
// later, or never drops it when writerStuck is set.
// Optional feature macro: EEPROM_SEQ_WATCHDOG_EN selects watchdog expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_eeprom_write_sequencer;

    localparam int TB_DEPTH   = 4;
    localparam int TB_TWR     = 100;
    localparam int TB_TIMEOUT = 200;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } req_t;

    logic        clk_50M;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_address;
    logic [7:0]  req_data;
    logic        write;
    logic [7:0]  write_control;
    logic [15:0] write_address;
    logic [7:0]  write_data;
    logic        wc;
    logic        busy;
    logic        done_pulse;
    logic [2:0]  pending;
    logic        error;

    req_t        model[$];
    int          cycle;
    int          passCount;
    int          checkCount;
    int          failCount;
    int          doneCount;
    int          acceptedCount;
    int          expectedDone;
    int          lastWcRise;
    int          riseCycle;
    int          wrTimer;
    int          doneBefore;
    bit          wrActive;
    bit          writerStuck;
    logic        expError;
    logic        prevWrite;
    logic [15:0] expAddr;
    logic [7:0]  expData;

    eeprom_write_sequencer #(
        .DEPTH          (TB_DEPTH),
        .TWR_CYCLES     (TB_TWR),
        .DEV_SEL        (3'b101),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk_50M        (clk_50M),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_address    (req_address),
        .req_data       (req_data),
        .write          (write),
        .write_control  (write_control),
        .write_address  (write_address),
        .write_data     (write_data),
        .write_complete (wc),
        .busy           (busy),
        .done_pulse     (done_pulse),
        .pending        (pending),
        .error          (error)
    );

    // Free-running 100 MHz-period bench clock (period value is arbitrary).
    initial begin
        clk_50M = 1'b0;
        forever #5 clk_50M = ~clk_50M;
    end

    // Hard stop in case something never settles.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: observed still running expected finished");
        $fatal(1, "[TB] aborting");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock, update the reference model and the writer model,
    // then compare every per-cycle output against the model.
    task automatic stepClock();
        bit   accepted;
        bit   rose;
        req_t r;
        accepted = req_valid && !reset && (model.size() < TB_DEPTH);
        rose     = 1'b0;
        @(posedge clk_50M);
        #1;
        cycle++;
        if (reset) begin
            model.delete();
            expectedDone = -1;
            lastWcRise   = -100000;
            wrActive     = 1'b0;
            wc           = 1'b1;
            expAddr      = '0;
            expData      = '0;
            expError     = 1'b0;
        end else begin
            if (write && !prevWrite) begin
                rose = 1'b1;
                checkOutput("launch_has_entry", 32'(model.size() != 0), 32'd1);
                if (model.size() != 0) begin
                    r       = model.pop_front();
                    expAddr = r.addr;
                    expData = r.data;
                end
                checkOutput("launch_spacing", 32'((cycle - lastWcRise) >= TB_TWR), 32'd1);
                riseCycle = cycle;
                wrActive  = 1'b1;
                wrTimer   = 0;
            end else if (!write && prevWrite) begin
                checkOutput("write_high_min2", 32'((cycle - riseCycle) >= 2), 32'd1);
`ifdef EEPROM_SEQ_WATCHDOG_EN
                if (writerStuck) begin
                    checkOutput("timeout_len", 32'(cycle - riseCycle), 32'(TB_TIMEOUT));
                    expError   = 1'b1;
                    lastWcRise = cycle;
                    wrActive   = 1'b0;
                end
`endif
            end
            if (wrActive && !writerStuck && !rose) begin
                wrTimer++;
                if (wrTimer == 2) begin
                    wc = 1'b0;
                end
                if (wrTimer == 52) begin
                    wc           = 1'b1;
                    wrActive     = 1'b0;
                    lastWcRise   = cycle;
                    expectedDone = cycle + TB_TWR;
                end
            end
            if (accepted) begin
                r.addr = req_address;
                r.data = req_data;
                model.push_back(r);
                acceptedCount++;
            end
        end
        checkOutput("pending", 32'(pending), 32'(model.size()));
        checkOutput("req_ready", 32'(req_ready), 32'(model.size() < TB_DEPTH));
        checkOutput("done_pulse", 32'(done_pulse), 32'(cycle == expectedDone));
        checkOutput("write_control", 32'(write_control), 32'h0000_00AA);
        checkOutput("write_address", 32'(write_address), 32'(expAddr));
        checkOutput("write_data", 32'(write_data), 32'(expData));
        checkOutput("error", 32'(error), 32'(expError));
        if (done_pulse) begin
            doneCount++;
        end
        prevWrite = write;
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] addr, input logic [7:0] data);
        req_valid   = valid;
        req_address = addr;
        req_data    = data;
        stepClock();
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (((busy !== 1'b0) || (model.size() != 0)) && (n < budget)) begin
            applyStimulus(1'b0, 16'h0000, 8'h00);
            n++;
        end
        checkOutput("idle_reached", 32'(busy), 32'd0);
        checkOutput("queue_drained", 32'(pending), 32'd0);
    endtask

    task automatic waitWriterLow(input int budget);
        int n;
        n = 0;
        while ((wc !== 1'b0) && (n < budget)) begin
            applyStimulus(1'b0, 16'h0000, 8'h00);
            n++;
        end
    endtask

    initial begin
        cycle         = 0;
        passCount     = 0;
        checkCount    = 0;
        failCount     = 0;
        doneCount     = 0;
        acceptedCount = 0;
        expectedDone  = -1;
        lastWcRise    = -100000;
        riseCycle     = 0;
        wrTimer       = 0;
        wrActive      = 1'b0;
        writerStuck   = 1'b0;
        expError      = 1'b0;
        prevWrite     = 1'b0;
        expAddr       = '0;
        expData       = '0;
        wc            = 1'b1;
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_address   = '0;
        req_data      = '0;

        $display("[TB] reset");
        repeat (3) applyStimulus(1'b0, 16'h0000, 8'h00);
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0000, 8'h00);
        checkOutput("rst_write", 32'(write), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_pending", 32'(pending), 32'd0);
        checkOutput("rst_addr", 32'(write_address), 32'd0);

        $display("[TB] single request");
        applyStimulus(1'b1, 16'h1234, 8'hA5);
        applyStimulus(1'b0, 16'h0000, 8'h00);
        checkOutput("single_write_high", 32'(write), 32'd1);
        checkOutput("single_addr", 32'(write_address), 32'h1234);
        checkOutput("single_data", 32'(write_data), 32'hA5);
        waitWriterLow(20);
        applyStimulus(1'b0, 16'h0000, 8'h00);
        checkOutput("single_xfer_write_low", 32'(write), 32'd0);
        checkOutput("single_xfer_busy", 32'(busy), 32'd1);

        $display("[TB] fill and order");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'(i), 8'(8'h11 * (i + 1)));
        end
        checkOutput("fill_ready_low", 32'(req_ready), 32'd0);
        checkOutput("fill_pending4", 32'(pending), 32'd4);
        applyStimulus(1'b1, 16'hBEEF, 8'h55);
        checkOutput("fifth_dropped", 32'(pending), 32'd4);
        waitIdle(2000);
        checkOutput("fill_done_count", 32'(doneCount), 32'd5);

        $display("[TB] simultaneous push and pop");
        applyStimulus(1'b1, 16'h0100, 8'h5A);
        checkOutput("simul_pending_before", 32'(pending), 32'd1);
        checkOutput("simul_idle_before", 32'(busy), 32'd0);
        applyStimulus(1'b1, 16'h0101, 8'hC3);
        checkOutput("simul_pending_after", 32'(pending), 32'd1);
        checkOutput("simul_launch", 32'(write), 32'd1);
        checkOutput("simul_addr", 32'(write_address), 32'h0100);
        waitIdle(1000);
        checkOutput("simul_done_count", 32'(doneCount), 32'd7);

        $display("[TB] random traffic");
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                applyStimulus(1'b1, 16'($urandom), 8'($urandom));
            end else begin
                applyStimulus(1'b0, 16'h0000, 8'h00);
            end
        end
        waitIdle(3000);
        checkOutput("random_done_matches_accepted", 32'(doneCount), 32'(acceptedCount));

        $display("[TB] reset during transfer");
        doneBefore = doneCount;
        applyStimulus(1'b1, 16'h0200, 8'h01);
        applyStimulus(1'b1, 16'h0201, 8'h02);
        applyStimulus(1'b1, 16'h0202, 8'h03);
        waitWriterLow(20);
        applyStimulus(1'b0, 16'h0000, 8'h00);
        checkOutput("midrst_in_xfer", 32'(busy), 32'd1);
        checkOutput("midrst_queued", 32'(pending), 32'd2);
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 8'h00);
        reset = 1'b0;
        checkOutput("midrst_write", 32'(write), 32'd0);
        checkOutput("midrst_pending", 32'(pending), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        repeat (150) applyStimulus(1'b0, 16'h0000, 8'h00);
        checkOutput("midrst_no_done", 32'(doneCount), 32'(doneBefore));
        checkOutput("midrst_still_idle", 32'(busy), 32'd0);

        $display("[TB] stuck writer");
        doneBefore  = doneCount;
        writerStuck = 1'b1;
`ifdef EEPROM_SEQ_WATCHDOG_EN
        applyStimulus(1'b1, 16'h0300, 8'h77);
        applyStimulus(1'b1, 16'h0301, 8'h88);
        waitIdle(1500);
        checkOutput("wd_error_set", 32'(error), 32'd1);
        checkOutput("wd_no_done", 32'(doneCount), 32'(doneBefore));
        checkOutput("wd_write_low", 32'(write), 32'd0);
        writerStuck = 1'b0;
        applyStimulus(1'b1, 16'h0302, 8'h99);
        waitIdle(1000);
        checkOutput("wd_error_sticky", 32'(error), 32'd1);
        checkOutput("wd_done_after", 32'(doneCount), 32'(doneBefore + 1));
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 8'h00);
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0000, 8'h00);
        checkOutput("wd_error_cleared", 32'(error), 32'd0);
`else
        applyStimulus(1'b1, 16'h0300, 8'h77);
        repeat (300) applyStimulus(1'b0, 16'h0000, 8'h00);
        checkOutput("nowd_write_held", 32'(write), 32'd1);
        checkOutput("nowd_error_low", 32'(error), 32'd0);
        checkOutput("nowd_busy", 32'(busy), 32'd1);
        checkOutput("nowd_no_done", 32'(doneCount), 32'(doneBefore));
        writerStuck = 1'b0;
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 8'h00);
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0000, 8'h00);
        checkOutput("nowd_reset_write", 32'(write), 32'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
